cnn_win_sched: RTL
==================

# cnn_win_sched

Window-fetch scheduler between the bit-wide input image RAM and `cnn_core`. It tracks how many pixel bits have been written and issues 3x3 convolution-window reads as soon as each window's last pixel is present and the core is idle. It streams the nine taps with valid, start and last markers, and signals when the full frame of windows has been delivered. It replaces the ad-hoc read state machine in the top level.

## Interface
- `IMG_W`, default 28: image width in pixels.
- `IMG_H`, default 28: image height in pixels.
- `K`, default 3: window edge length; 9 taps per window.
- `AW`, default 10: RAM address width.
- `clk` in 1: single clock for all state.
- `rst` in 1: reset, synchronous and active-high.
- `frame_clr` in 1: one-cycle pulse; abort and restart scheduling for a new frame.
- `wr_addr` in AW: count of pixel bits written so far (write pointer).
- `core_bsy` in 1: core busy; no new window starts while high.
- `ram_rd` out 1: read strobe to the RAM.
- `ram_addr` out AW: read address; 0 when `ram_rd` is low.
- `tap_vld` out 1: RAM dout holds a tap this cycle.
- `tap_idx` out 4: tap number 0..8 while `tap_vld` is high.
- `win_strt` out 1: coincides with tap 0 valid; drives core `strt`.
- `win_last` out 1: coincides with tap 8 valid.
- `frame_done` out 1: one-cycle pulse after the last window's tap 8.
- `win_cnt` out 10: windows completed in this frame.

## Operation
- States and transitions:
  - WAIT → FETCH when `anchor < wr_addr` (unsigned, AW bits) and `!core_bsy`.
  - FETCH holds for 9 cycles, `tap` 0..8, then → ADV.
  - ADV → DONE if this was the last window, else → WAIT.
  - DONE holds until `frame_clr` or `rst`.
- `anchor` is the bottom-right pixel address of the current window. Its initial value is `(K-1)*IMG_W+(K-1)` (58).
- FETCH tap t drives `ram_rd=1` and `ram_addr = anchor - off[t]`.
  - Offsets in order: 58, 57, 56, 30, 29, 28, 2, 1, 0.
  - General form: `(K-1-r)*IMG_W + (K-1-c)`, row-major.
- ADV updates the counters:
  - `col` counts 0..`IMG_W-K` (25).
  - At `col==IMG_W-K`: `col←0`, `anchor←anchor+K`.
  - Otherwise: `col←col+1`, `anchor←anchor+1`.
  - `win_cnt` increments every ADV.
- The last window is `win_cnt==(IMG_W-K+1)*(IMG_H-K+1)-1` (675) in ADV. Its anchor is 783.
- Once FETCH is entered the window completes without stalls. `core_bsy` is sampled only in WAIT.
- `frame_clr` (any state):
  - Next state is WAIT.
  - `anchor`, `col` and `win_cnt` return to their initial values.
  - The in-flight tap's `tap_vld`, `win_strt` and `win_last` are suppressed.
- `rst` behaves as `frame_clr` and also clears all outputs. `rst` has priority over `frame_clr`.
- `wr_addr` decreasing (a new frame write without `frame_clr`) is not a supported sequence. The block simply waits on the compare.
- All address arithmetic is AW-bit unsigned. `anchor` never exceeds `IMG_W*IMG_H-1`.

## Timing
- Reset values:
  - State WAIT, `anchor` 58, `col` 0, `win_cnt` 0.
  - Outputs `ram_rd` 0, `ram_addr` 0, `tap_vld` 0, `tap_idx` 0, `win_strt` 0, `win_last` 0, `frame_done` 0.
- RAM read latency is 1 cycle.
  - `ram_rd`/`ram_addr` are combinational from state and `tap`.
  - `tap_vld`, `tap_idx`, `win_strt` and `win_last` are registered copies, one cycle later.
- Condition true in WAIT at cycle n:
  - Taps 0..8 are addressed in cycles n+1..n+9.
  - `tap_vld` is high for cycles n+2..n+10.
  - ADV occurs at n+10.
  - The earliest next WAIT decision is at n+11.
- Minimum window period is 11 cycles. `frame_done` is high in the cycle after the final ADV (the DONE entry cycle).
- `core_bsy` rising in the same cycle as WAIT's decision blocks the start, because the decision is combinational on the current value.

## Structure
- Shared package `cnn_pkg` holds:
  - `IMG_W`, `IMG_H` and `K` defaults.
  - The `sched_state_t` enum {WAIT, FETCH, ADV, DONE}.
  - The tap offset function `tap_off(t)`.
- Sub-module `cnn_anchor_cnt` owns `anchor`, `col` and `win_cnt`. It has inputs `clr` and `adv`, and outputs `anchor`, `win_cnt` and `last_win`.
- The FSM, tap counter and output pipeline register live in `cnn_win_sched`.

## Test plan
- First window gating: `rst`, then `wr_addr=58` for 50 cycles, giving no `ram_rd`. Then set `wr_addr=59`, which reads addresses 0,1,2,28,29,30,56,57,58. `win_strt` coincides with tap 0 valid and `win_last` with tap 8, 11 cycles per window.
- Row wrap: `wr_addr=784`, `core_bsy=0`. Window 25 has anchor 83 (first address 25). Window 26 has anchor 86 and its first address is 28.
- Back-pressure: `core_bsy=1` while windows are available leaves the block in WAIT with no `ram_rd`. Dropping `core_bsy` starts the fetch on the next cycle.
- Full frame: `wr_addr=784` produces exactly 676 windows. The last tap address is 783, `frame_done` pulses once, `win_cnt=676`, and there are no further reads.
- Abort: `frame_clr` at FETCH tap 4 gives no `tap_vld` for taps 4..8. The next window read starts at address 0 and `win_cnt` is 0.
- Priority: `rst` and `frame_clr` together, mid-FETCH, leave all outputs 0 and the state WAIT the next cycle.

Source files
------------

// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN window-fetch path: image geometry defaults,
// scheduler state encoding and the 3x3 tap offset helper.
package cnn_pkg;

  localparam int unsigned IMG_W_DEF = 32'd28;
  localparam int unsigned IMG_H_DEF = 32'd28;
  localparam int unsigned K_DEF     = 32'd3;

  typedef enum logic [1:0] {
    WAIT  = 2'd0,
    FETCH = 2'd1,
    ADV   = 2'd2,
    DONE  = 2'd3
  } sched_state_t;

  // Distance from the window's bottom-right anchor back to tap t (row-major).
  function automatic int unsigned tap_off(input int unsigned t,
                                          input int unsigned img_w,
                                          input int unsigned k);
    int unsigned r;
    int unsigned c;
    r = t / k;
    c = t % k;
    return (k - 32'd1 - r) * img_w + (k - 32'd1 - c);
  endfunction

endpackage

// File: rtl/cnn_anchor_cnt.sv
// Window position bookkeeping: anchor (bottom-right pixel address), column
// within the current window row, and completed-window count.
module cnn_anchor_cnt
  import cnn_pkg::*;
#(
  parameter int unsigned IMG_W = IMG_W_DEF,
  parameter int unsigned IMG_H = IMG_H_DEF,
  parameter int unsigned K     = K_DEF,
  parameter int unsigned AW    = 32'd10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          adv,
  output logic [AW-1:0] anchor,
  output logic [9:0]    win_cnt,
  output logic          last_win
);

  localparam int unsigned COLS    = IMG_W - K + 32'd1;
  localparam int unsigned ROWS    = IMG_H - K + 32'd1;
  localparam int unsigned NWIN    = COLS * ROWS;
  localparam int unsigned CW      = $clog2(IMG_W);
  localparam logic [AW-1:0] ANCHOR0 = AW'((K - 32'd1) * IMG_W + (K - 32'd1));
  localparam logic [CW-1:0] COL_LAST = CW'(COLS - 32'd1);
  localparam logic [9:0]    WIN_LAST = 10'(NWIN - 32'd1);

  logic [AW-1:0] anchor_q;
  logic [CW-1:0] col_q;
  logic [9:0]    win_cnt_q;

  // Advance the anchor one pixel, or skip the K-1 edge columns on row wrap;
  // the final window keeps its anchor so it never leaves the image.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      anchor_q  <= ANCHOR0;
      col_q     <= {CW{1'b0}};
      win_cnt_q <= 10'd0;
    end else if (adv) begin
      win_cnt_q <= win_cnt_q + 10'd1;
      if (!last_win) begin
        if (col_q == COL_LAST) begin
          col_q    <= {CW{1'b0}};
          anchor_q <= anchor_q + AW'(K);
        end else begin
          col_q    <= col_q + CW'(1);
          anchor_q <= anchor_q + AW'(1);
        end
      end
    end
  end

  assign anchor   = anchor_q;
  assign win_cnt  = win_cnt_q;
  assign last_win = (win_cnt_q == WIN_LAST);

endmodule

// File: rtl/cnn_win_sched.sv
// Window-fetch scheduler: waits for each window's last pixel to be written and
// the core to be idle, then streams the nine taps out of the 1-cycle image RAM.
module cnn_win_sched
  import cnn_pkg::*;
#(
  parameter int unsigned IMG_W = IMG_W_DEF,
  parameter int unsigned IMG_H = IMG_H_DEF,
  parameter int unsigned K     = K_DEF,
  parameter int unsigned AW    = 32'd10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          frame_clr,
  input  logic [AW-1:0] wr_addr,
  input  logic          core_bsy,
  output logic          ram_rd,
  output logic [AW-1:0] ram_addr,
  output logic          tap_vld,
  output logic [3:0]    tap_idx,
  output logic          win_strt,
  output logic          win_last,
  output logic          frame_done,
  output logic [9:0]    win_cnt
);

  localparam logic [3:0] LAST_TAP = 4'(K * K - 32'd1);

  sched_state_t  state_q;
  logic [3:0]    tap_q;
  logic          tap_vld_q;
  logic [3:0]    tap_idx_q;
  logic          win_strt_q;
  logic          win_last_q;
  logic          frame_done_q;

  logic [AW-1:0] anchor_s;
  logic          last_win_s;
  logic          fetch_s;
  logic          start_s;
  logic          adv_s;
  logic [AW-1:0] rd_addr_s;

  cnn_anchor_cnt #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .K     (K),
    .AW    (AW)
  ) u_anchor (
    .clk      (clk),
    .rst      (rst),
    .clr      (frame_clr),
    .adv      (adv_s),
    .anchor   (anchor_s),
    .win_cnt  (win_cnt),
    .last_win (last_win_s)
  );

  // Start decision uses the live core_bsy, so a same-cycle busy blocks it.
  always_comb begin
    fetch_s   = (state_q == FETCH);
    adv_s     = (state_q == ADV);
    start_s   = (state_q == WAIT) && (anchor_s < wr_addr) && !core_bsy;
    rd_addr_s = anchor_s - AW'(tap_off(32'(tap_q), IMG_W, K));
    if (fetch_s) begin
      ram_rd   = 1'b1;
      ram_addr = rd_addr_s;
    end else begin
      ram_rd   = 1'b0;
      ram_addr = {AW{1'b0}};
    end
  end

  // Scheduler FSM plus the tap marker pipeline aligned to RAM read data.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= WAIT;
      tap_q        <= 4'd0;
      tap_vld_q    <= 1'b0;
      tap_idx_q    <= 4'd0;
      win_strt_q   <= 1'b0;
      win_last_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      tap_vld_q    <= fetch_s && !frame_clr;
      tap_idx_q    <= fetch_s ? tap_q : 4'd0;
      win_strt_q   <= fetch_s && (tap_q == 4'd0) && !frame_clr;
      win_last_q   <= fetch_s && (tap_q == LAST_TAP) && !frame_clr;
      frame_done_q <= adv_s && last_win_s && !frame_clr;
      if (frame_clr) begin
        state_q <= WAIT;
        tap_q   <= 4'd0;
      end else begin
        case (state_q)
          WAIT: begin
            if (start_s) begin
              state_q <= FETCH;
              tap_q   <= 4'd0;
            end
          end
          FETCH: begin
            if (tap_q == LAST_TAP) begin
              state_q <= ADV;
              tap_q   <= 4'd0;
            end else begin
              tap_q <= tap_q + 4'd1;
            end
          end
          ADV: begin
            state_q <= last_win_s ? DONE : WAIT;
          end
          DONE: begin
            state_q <= DONE;
          end
          default: begin
            state_q <= WAIT;
            tap_q   <= 4'd0;
          end
        endcase
      end
    end
  end

  assign tap_vld    = tap_vld_q;
  assign tap_idx    = tap_idx_q;
  assign win_strt   = win_strt_q;
  assign win_last   = win_last_q;
  assign frame_done = frame_done_q;

endmodule
